// File: rtl/pwm_reader_block.sv
// Measures the high time of one RC-receiver PWM channel in microseconds and
// turns it into a motor-scale command value, with a loss-of-signal failsafe.
module pwm_reader_block #(
    parameter int OUTPUT_BIT_WIDTH = 10,
    parameter int MIN_HIGH_US      = 1000,
    parameter int MAX_HIGH_US      = 2000,
    parameter int MIN_VALID_US     = 800,
    parameter int MAX_VALID_US     = 2200,
    parameter int TIMEOUT_US       = 25000
) (
    input  logic                        us_clk,
    input  logic                        resetn,
    input  logic                        pwm_in,
    output logic [OUTPUT_BIT_WIDTH-1:0] rx_value,
    output logic                        value_valid,
    output logic                        signal_lost,
    output logic [2:0]                  state_out
);

    localparam int TW = $clog2(TIMEOUT_US + 1);
    localparam logic [15:0]   MIN_HIGH    = 16'(MIN_HIGH_US);
    localparam logic [15:0]   MAX_HIGH    = 16'(MAX_HIGH_US);
    localparam logic [15:0]   MIN_VALID   = 16'(MIN_VALID_US);
    localparam logic [15:0]   MAX_VALID   = 16'(MAX_VALID_US);
    localparam logic [15:0]   OUT_MAX     = 16'((2 ** OUTPUT_BIT_WIDTH) - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_US);

    typedef enum logic [2:0] {
        WAIT_LOW  = 3'b001,
        WAIT_HIGH = 3'b010,
        MEASURE   = 3'b100
    } state_t;

    state_t                      state_q, state_d;
    logic                        sync1_q, s_q, s_prev_q;
    logic [1:0]                  prime_q;
    logic [15:0]                 width_q, width_d;
    logic [TW-1:0]               timeout_q, timeout_d;
    logic [OUTPUT_BIT_WIDTH-1:0] rx_value_q, rx_value_d;
    logic                        value_valid_q, value_valid_d;
    logic                        signal_lost_q, signal_lost_d;
    logic                        rise, fall, accept;
    logic [15:0]                 clamped, scaled;
    logic [OUTPUT_BIT_WIDTH-1:0] scaled_out;

    assign rise = s_q & ~s_prev_q;
    assign fall = ~s_q & s_prev_q;

    // The synchronizer resets to 0, so its output is only trusted once it has
    // filled with real samples; otherwise a pulse in progress at reset would
    // look like a fresh rising edge.
    always_comb begin
        state_d = state_q;
        width_d = width_q;
        accept  = 1'b0;
        case (state_q)
            WAIT_LOW: begin
                if (!s_q && prime_q[1]) begin
                    state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rise) begin
                    width_d = 16'd1;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (s_q) begin
                    if (width_q >= MAX_VALID) begin
                        width_d = MAX_VALID + 16'd1;
                        state_d = WAIT_LOW;
                    end else begin
                        width_d = width_q + 16'd1;
                    end
                end else if (fall) begin
                    state_d = WAIT_HIGH;
                    accept  = (width_q >= MIN_VALID) && (width_q <= MAX_VALID);
                end
            end
            default: state_d = WAIT_LOW;
        endcase
    end

    always_comb begin
        clamped = width_q;
        if (width_q < MIN_HIGH) begin
            clamped = MIN_HIGH;
        end else if (width_q > MAX_HIGH) begin
            clamped = MAX_HIGH;
        end
        scaled     = clamped - MIN_HIGH;
        scaled_out = (scaled > OUT_MAX) ? OUT_MAX[OUTPUT_BIT_WIDTH-1:0]
                                        : scaled[OUTPUT_BIT_WIDTH-1:0];
    end

    // An accepted pulse takes priority over the failsafe in the same cycle.
    always_comb begin
        timeout_d     = (timeout_q >= TIMEOUT_MAX) ? TIMEOUT_MAX : timeout_q + 1'b1;
        value_valid_d = accept;
        rx_value_d    = rx_value_q;
        signal_lost_d = signal_lost_q;
        if (accept) begin
            timeout_d     = '0;
            rx_value_d    = scaled_out;
            signal_lost_d = 1'b0;
        end else if (timeout_d == TIMEOUT_MAX) begin
            rx_value_d    = '0;
            signal_lost_d = 1'b1;
        end
    end

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= WAIT_LOW;
            sync1_q       <= 1'b0;
            s_q           <= 1'b0;
            s_prev_q      <= 1'b0;
            prime_q       <= 2'b00;
            width_q       <= '0;
            timeout_q     <= '0;
            rx_value_q    <= '0;
            value_valid_q <= 1'b0;
            signal_lost_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            sync1_q       <= pwm_in;
            s_q           <= sync1_q;
            s_prev_q      <= s_q;
            prime_q       <= {prime_q[0], 1'b1};
            width_q       <= width_d;
            timeout_q     <= timeout_d;
            rx_value_q    <= rx_value_d;
            value_valid_q <= value_valid_d;
            signal_lost_q <= signal_lost_d;
        end
    end

    assign rx_value    = rx_value_q;
    assign value_valid = value_valid_q;
    assign signal_lost = signal_lost_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_pwm_reader_block.sv
// Self-checking bench for pwm_reader_block: pulse-level reference model that
// schedules expected strobes and derives timeout/failsafe from elapsed cycles.
`timescale 1ns/1ps
module tb_pwm_reader_block;

    localparam int W       = 10;
    localparam int TIMEOUT = 25000;

    logic         us_clk = 1'b0;
    logic         resetn;
    logic         pwm_in;
    logic [W-1:0] rx_value;
    logic         value_valid;
    logic         signal_lost;
    logic [2:0]   state_out;

    int checks = 0;
    int errors = 0;

    // Reference model state: pulse bookkeeping plus the last accepted result.
    int cyc;
    int run_len;
    bit armed;
    bit never_acc;
    int last_acc;
    int last_val;
    int strobe_edge_q[$];
    int strobe_val_q[$];

    pwm_reader_block dut (
        .us_clk      (us_clk),
        .resetn      (resetn),
        .pwm_in      (pwm_in),
        .rx_value    (rx_value),
        .value_valid (value_valid),
        .signal_lost (signal_lost),
        .state_out   (state_out)
    );

    always #5 us_clk = ~us_clk;

    function automatic int scale(input int w);
        int v;
        v = (w < 1000) ? 1000 : ((w > 2000) ? 2000 : w);
        v = v - 1000;
        if (v > (2 ** W) - 1) v = (2 ** W) - 1;
        return v;
    endfunction

    task automatic printSummary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     tag, observed, expected, cyc);
            if (errors >= 20) printSummary();
        end
    endtask

    task automatic applyReset(input logic level);
        resetn = 1'b0;
        pwm_in = level;
        repeat (3) @(negedge us_clk);
        checkOutput("reset_rx", 32'(rx_value), 32'd0);
        checkOutput("reset_valid", 32'(value_valid), 32'd0);
        checkOutput("reset_lost", 32'(signal_lost), 32'd1);
        checkOutput("reset_state", 32'(state_out), 32'd1);
        resetn    = 1'b1;
        cyc       = 0;
        run_len   = 0;
        armed     = !level;
        never_acc = 1'b1;
        last_acc  = 0;
        last_val  = 0;
        strobe_edge_q.delete();
        strobe_val_q.delete();
    endtask

    // One us_clk cycle: drive pwm_in, advance the model, compare all outputs.
    task automatic applyStimulus(input logic drive);
        logic       exp_vv, exp_lost;
        int         exp_rx;
        logic [11:0] exp_pack;
        if (!drive && run_len > 0) begin
            if (armed && run_len >= 800 && run_len <= 2200) begin
                strobe_edge_q.push_back(cyc + 3);
                strobe_val_q.push_back(scale(run_len));
            end
            armed = 1'b1;
        end
        run_len = drive ? run_len + 1 : 0;
        pwm_in  = drive;
        @(posedge us_clk);
        cyc++;
        exp_vv = 1'b0;
        if (strobe_edge_q.size() > 0 && strobe_edge_q[0] == cyc) begin
            void'(strobe_edge_q.pop_front());
            last_val  = strobe_val_q.pop_front();
            last_acc  = cyc;
            never_acc = 1'b0;
            exp_vv    = 1'b1;
        end
        exp_lost = never_acc || (cyc - last_acc >= TIMEOUT);
        exp_rx   = exp_lost ? 0 : last_val;
        exp_pack = {exp_vv, exp_lost, exp_rx[W-1:0]};
        @(negedge us_clk);
        checkOutput("outputs", 32'({value_valid, signal_lost, rx_value}), 32'(exp_pack));
    endtask

    task automatic send_pulse(input int width, input int gap);
        repeat (width) applyStimulus(1'b1);
        repeat (gap) applyStimulus(1'b0);
    endtask

    initial begin
        int fixed_w[4];
        int fixed_v[4];
        int n0;
        int last_strobe;
        int a;
        int w;
        fixed_w = '{900, 1000, 2000, 2100};
        fixed_v = '{0, 0, 1000, 1000};

        applyReset(1'b0);

        repeat (10) applyStimulus(1'b0);
        send_pulse(1500, 18500);
        send_pulse(1500, 100);
        checkOutput("t1_rx", 32'(rx_value), 32'd500);
        checkOutput("t1_lost", 32'(signal_lost), 32'd0);

        for (int i = 0; i < 4; i++) begin
            send_pulse(fixed_w[i], $urandom_range(50, 300));
            checkOutput("t2_rx", 32'(rx_value), 32'(fixed_v[i]));
            checkOutput("t2_state", 32'(state_out), 32'd2);
        end

        send_pulse(50, $urandom_range(50, 300));
        send_pulse(799, $urandom_range(50, 300));
        n0 = cyc;
        for (int i = 0; i < 2300; i++) begin
            applyStimulus(1'b1);
            if (cyc == n0 + 2202) checkOutput("t3_measure", 32'(state_out), 32'd4);
            if (cyc == n0 + 2203) checkOutput("t3_abort", 32'(state_out), 32'd1);
        end
        repeat (100) applyStimulus(1'b0);
        checkOutput("t3_rx", 32'(rx_value), 32'd1000);

        for (int i = 0; i < 2; i++) begin
            w = $urandom_range(800, 2200);
            send_pulse(w, $urandom_range(50, 300));
            checkOutput("rand_rx", 32'(rx_value), 32'(scale(w)));
        end

        send_pulse(1200, 300);
        send_pulse(1200, 0);
        last_strobe = cyc + 3;
        while (cyc < last_strobe + TIMEOUT + 5) begin
            applyStimulus(1'b0);
            if (cyc == last_strobe + TIMEOUT - 1)
                checkOutput("t4_lost_before", 32'(signal_lost), 32'd0);
            if (cyc == last_strobe + TIMEOUT) begin
                checkOutput("t4_lost", 32'(signal_lost), 32'd1);
                checkOutput("t4_failsafe_rx", 32'(rx_value), 32'd0);
            end
        end
        send_pulse(1200, 100);
        checkOutput("t4_restore_rx", 32'(rx_value), 32'd200);
        checkOutput("t4_restore_lost", 32'(signal_lost), 32'd0);

        // Rejected glitches and stuck-high pulses must not refresh the timeout.
        a  = last_acc;
        n0 = a + TIMEOUT - 3 - 1500;
        while (cyc + 2600 + 300 + 20 < n0) begin
            w = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 799) : $urandom_range(2201, 2600);
            send_pulse(w, $urandom_range(20, 300));
        end
        while (cyc < n0) applyStimulus(1'b0);
        repeat (1500) applyStimulus(1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0);
            if (cyc == a + TIMEOUT) begin
                checkOutput("t6_valid", 32'(value_valid), 32'd1);
                checkOutput("t6_lost", 32'(signal_lost), 32'd0);
                checkOutput("t6_rx", 32'(rx_value), 32'd500);
            end
        end

        applyReset(1'b1);
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(1'b1);
            if (i == 100) checkOutput("t5_hold_state", 32'(state_out), 32'd1);
        end
        repeat (300) applyStimulus(1'b0);
        checkOutput("t5_ignored_rx", 32'(rx_value), 32'd0);
        send_pulse(1700, 100);
        checkOutput("t5_rx", 32'(rx_value), 32'd700);
        repeat (400) applyStimulus(1'b1);
        #2 resetn = 1'b0;
        #1;
        checkOutput("t5_async_rx", 32'(rx_value), 32'd0);
        checkOutput("t5_async_valid", 32'(value_valid), 32'd0);
        checkOutput("t5_async_lost", 32'(signal_lost), 32'd1);
        checkOutput("t5_async_state", 32'(state_out), 32'd1);

        printSummary();
    end

endmodule
